// File: rtl/fact_accel_pkg.sv
// Shared definitions for the memory-mapped factorial accelerator:
// register offsets, STATUS bit positions, FSM encoding and limits.
package fact_accel_pkg;

    localparam logic [1:0] A_N      = 2'd0;
    localparam logic [1:0] A_GO     = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_RESULT = 2'd3;

    localparam int ST_DONE = 0;
    localparam int ST_ERR  = 1;
    localparam int ST_BUSY = 2;

    localparam int FACT_MAX_N = 12;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/fact_core.sv
// Iterative factorial engine: one DATA_W x N_W multiply per BUSY cycle,
// counting the latched operand down to 1.
module fact_core
    import fact_accel_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_W    = 4,
    parameter int MAX_N  = FACT_MAX_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [N_W-1:0]    n,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic [DATA_W-1:0] result
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N_W-1:0]      r_cnt;
    logic [N_W-1:0]      w_cnt_nxt;
    logic [DATA_W-1:0]   r_prod;
    logic [DATA_W-1:0]   w_prod_nxt;
    logic [DATA_W-1:0]   r_result;
    logic [DATA_W-1:0]   w_result_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                r_err;
    logic                w_err_nxt;
    logic [DATA_W-1:0]   w_mul;

    assign w_mul = r_prod * DATA_W'(r_cnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_prod   <= w_prod_nxt;
            r_result <= w_result_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_prod_nxt   = r_prod;
        w_result_nxt = r_result;
        w_done_nxt   = r_done;
        w_err_nxt    = r_err;
        unique case (r_state)
            S_IDLE: begin
                if (go) begin
                    if (32'(n) > MAX_N) begin
                        // out-of-range operand: flag immediately, keep RESULT
                        w_done_nxt = 1'b1;
                        w_err_nxt  = 1'b1;
                    end else begin
                        w_done_nxt  = 1'b0;
                        w_err_nxt   = 1'b0;
                        w_cnt_nxt   = n;
                        w_prod_nxt  = DATA_W'(1);
                        w_state_nxt = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (r_cnt <= N_W'(1)) begin
                    w_result_nxt = r_prod;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_prod_nxt = w_mul;
                    w_cnt_nxt  = r_cnt - N_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign done   = r_done;
    assign err    = r_err;
    assign busy   = (r_state == S_BUSY);
    assign result = r_result;

endmodule

// File: rtl/fact_accel.sv
// Bus-facing wrapper: N register, GO strobe decode and the
// combinational read mux around the factorial engine.
module fact_accel
    import fact_accel_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_W    = 4,
    parameter int MAX_N  = FACT_MAX_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [1:0]        a,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd
);

    logic [N_W-1:0]    r_n;
    logic              w_go;
    logic              w_done;
    logic              w_err;
    logic              w_busy;
    logic [DATA_W-1:0] w_result;
    logic [DATA_W-1:0] w_status;
    logic              w_unused;

    assign w_unused = &{1'b0, wd[DATA_W-1:N_W]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_n <= '0;
        end else if (we && (a == A_N)) begin
            r_n <= wd[N_W-1:0];
        end
    end

    assign w_go = we && (a == A_GO) && wd[0];

    fact_core #(
        .DATA_W (DATA_W),
        .N_W    (N_W),
        .MAX_N  (MAX_N)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .go     (w_go),
        .n      (r_n),
        .done   (w_done),
        .err    (w_err),
        .busy   (w_busy),
        .result (w_result)
    );

    always_comb begin
        w_status          = '0;
        w_status[ST_DONE] = w_done;
        w_status[ST_ERR]  = w_err;
        w_status[ST_BUSY] = w_busy;
    end

    always_comb begin
        rd = '0;
        unique case (a)
            A_N:      rd = DATA_W'(r_n);
            A_GO:     rd = '0;
            A_STATUS: rd = w_status;
            A_RESULT: rd = w_result;
            default:  rd = '0;
        endcase
    end

endmodule

// File: tb/tb_fact_accel.sv
// Self-checking bench for fact_accel: directed scenarios plus random
// operands compared against a plain-arithmetic factorial model.
module tb_fact_accel;

    logic        clk;
    logic        rst;
    logic        we;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] m_result;
    logic [31:0] v;
    int          bcnt;
    int          nn;

    fact_accel #(.DATA_W(32), .N_W(4), .MAX_N(12)) dut (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .a   (a),
        .wd  (wd),
        .rd  (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] fact(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 2; i <= n; i++) p = p * 64'(i);
        return p[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [1:0] ad, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1;
        a  = ad;
        wd = d;
        @(posedge clk);
        #1;
        we = 1'b0;
        wd = '0;
    endtask

    task automatic rdr(input logic [1:0] ad, output logic [31:0] val);
        a = ad;
        #1;
        val = rd;
    endtask

    // Issue GO and count BUSY samples after each edge until idle.
    task automatic go_and_wait(output int cycles);
        logic [31:0] s;
        cycles = 0;
        wr(2'd1, 32'd1);
        for (int k = 0; k < 64; k++) begin
            rdr(2'd2, s);
            if (!s[2]) return;
            cycles++;
            @(posedge clk);
            #1;
        end
        chk("busy_timeout", 32'(cycles), 32'd0);
    endtask

    // Run one operand and compare against the model.
    task automatic run_n(input int n, input string tag);
        logic [31:0] s;
        logic [31:0] r;
        int          c;
        int          exp_c;
        logic [31:0] exp_s;
        wr(2'd0, 32'(n));
        go_and_wait(c);
        if (n > 12) begin
            exp_c = 0;
            exp_s = 32'h3;
        end else begin
            exp_c    = (n < 1) ? 1 : n;
            exp_s    = 32'h1;
            m_result = fact(n);
        end
        rdr(2'd2, s);
        rdr(2'd3, r);
        chk({tag, "_cycles"}, 32'(c), 32'(exp_c));
        chk({tag, "_status"}, s, exp_s);
        chk({tag, "_result"}, r, m_result);
    endtask

    initial begin
        rst      = 1'b0;
        we       = 1'b0;
        a        = 2'd0;
        wd       = '0;
        m_result = '0;
        #12;
        for (int i = 0; i < 4; i++) begin
            rdr(2'(i), v);
            chk($sformatf("reset_rd%0d", i), v, 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rdr(2'd2, v);
        chk("post_release_status", v, 32'd0);

        run_n(5, "n5");
        run_n(0, "n0");
        run_n(1, "n1");
        run_n(12, "n12");
        run_n(13, "n13");

        wr(2'd0, 32'd7);
        wr(2'd1, 32'd0);
        rdr(2'd2, v);
        chk("go0_noeffect", v, 32'h3);
        wr(2'd2, 32'hFFFF_FFFF);
        wr(2'd3, 32'h1234_5678);
        rdr(2'd3, v);
        chk("ro_result", v, m_result);
        rdr(2'd0, v);
        chk("n_readback", v, 32'd7);
        rdr(2'd1, v);
        chk("go_reads0", v, 32'd0);

        wr(2'd0, 32'd6);
        wr(2'd1, 32'd1);
        @(posedge clk);
        #1;
        wr(2'd0, 32'd3);
        wr(2'd1, 32'd1);
        for (int k = 0; k < 32; k++) begin
            rdr(2'd2, v);
            if (!v[2]) break;
            @(posedge clk);
            #1;
        end
        m_result = fact(6);
        rdr(2'd2, v);
        chk("midrun_status", v, 32'h1);
        rdr(2'd3, v);
        chk("midrun_result", v, m_result);
        rdr(2'd0, v);
        chk("midrun_n", v, 32'd3);
        go_and_wait(bcnt);
        m_result = fact(3);
        rdr(2'd3, v);
        chk("later_go_result", v, m_result);
        chk("later_go_cycles", 32'(bcnt), 32'd3);

        wr(2'd0, 32'd2);
        wr(2'd1, 32'd1);
        @(posedge clk);
        #1;
        wr(2'd1, 32'd1);
        m_result = fact(2);
        rdr(2'd2, v);
        chk("go_at_finish_status", v, 32'h1);
        rdr(2'd3, v);
        chk("go_at_finish_result", v, m_result);

        wr(2'd0, 32'd10);
        wr(2'd1, 32'd1);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            rdr(2'(i), v);
            chk($sformatf("abort_rd%0d", i), v, 32'd0);
        end
        m_result = '0;
        @(negedge clk);
        rst = 1'b1;
        run_n(4, "after_abort");

        for (int i = 0; i < 10; i++) begin
            nn = int'($urandom_range(0, 15));
            run_n(nn, $sformatf("rand%0d_n%0d", i, nn));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fact_accel.md
FACT_ACCEL -- requirements
Module: fact_accel

Interface
REQ-001 Parameter DATA_W, default 32: width of the bus data and of the result.
REQ-002 Parameter N_W, default 4: width of the operand register n.
REQ-003 Parameter MAX_N, default 12: largest n whose factorial fits in DATA_W bits.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset; this is fixed.
REQ-006 we  in  1  write strobe from the CPU store path, qualified by the address decoder.
REQ-007 a  in  2  word offset (byte address bits [3:2]) within the 16-byte window.
REQ-008 wd  in  DATA_W  store data (CPU register rt value).
REQ-009 rd  out  DATA_W  load data returned to the CPU writeback mux.

Function
REQ-010 Register map SHALL be: a=0 N (rw, N_W bits); a=1 GO (wo, bit0); a=2 STATUS (ro: bit0 done, bit1 err, bit2 busy); a=3 RESULT (ro).
REQ-011 rd SHALL be combinational from a: N zero-extended; GO reads 0; STATUS {29'b0,busy,err,done}; RESULT.
REQ-012 A write to N (we=1, a=0) SHALL load wd[N_W-1:0] at the edge, in any state.
REQ-013 Writes to a=2 or a=3 SHALL be ignored.
REQ-014 FSM states SHALL be IDLE and BUSY only; busy = (state==BUSY).
REQ-015 At an IDLE edge with a GO write and wd[0]=1: clear done and err.
REQ-016 In the case of REQ-015, if N > MAX_N: set err=1 and done=1, leave RESULT unchanged, stay IDLE.
REQ-017 In the case of REQ-015, if N <= MAX_N: cnt<=N, prod<=1, go to BUSY.
REQ-018 A GO write with wd[0]=0 SHALL have no effect.
REQ-019 BUSY, cnt<=1 at edge: RESULT<=prod, done<=1, go to IDLE.
REQ-020 BUSY, cnt>1 at edge: prod<=prod*cnt (truncated to DATA_W), cnt<=cnt-1.
REQ-021 Latency SHALL be exactly max(N,1) edges in BUSY after the GO edge; done is readable the cycle after the final edge.
REQ-022 A GO write while BUSY SHALL be ignored (no restart, flags untouched).
REQ-023 An N write while BUSY SHALL update N without affecting the running computation; the operand is latched in cnt.
REQ-024 A GO write in the same cycle as the finishing edge SHALL be ignored; the state is still BUSY at that edge.
REQ-025 done and err SHALL stay set until the next accepted GO.
REQ-026 RESULT SHALL hold its last value until the next successful completion.

Reset
REQ-027 On rst low, asynchronously: state=IDLE, N=0, cnt=0, prod=0, RESULT=0, done=0, err=0.
REQ-028 rd SHALL then reflect those values: STATUS=0, RESULT=0.
REQ-029 A reset during BUSY SHALL abort the computation with no completion flag.
REQ-030 Release of rst SHALL take effect at the next rising edge with no spurious GO.

Structure
REQ-031 A shared package/header SHALL hold the register offsets (A_N=0, A_GO=1, A_STATUS=2, A_RESULT=3), STATUS bit positions, the IDLE/BUSY state encoding and MAX_N.
REQ-032 Sub-module fact_core SHALL contain the FSM, cnt, prod and the multiplier, with ports go, n, done, err, busy and result.
REQ-033 fact_accel SHALL contain the register decode and the read mux around fact_core.
REQ-034 The multiplier SHALL be a single combinational DATA_W x N_W product per cycle, with no pipelining.

Verification
REQ-035 Reset, then read all four offsets -> rd = 0 for each.
REQ-036 Write N=5 and GO=1; poll STATUS -> busy for exactly 5 cycles, then STATUS=0x1 and RESULT=120 (0x78).
REQ-037 N=0, then N=1 -> each completes after 1 BUSY cycle with RESULT=1; N=12 -> RESULT=479001600 (0x1C8CFC00).
REQ-038 N=13 then GO -> next cycle STATUS=0x3 (err, done, not busy); RESULT keeps its previous value; no BUSY cycles occur.
REQ-039 N=6 with GO; mid-run write N=3 and GO -> RESULT=720; the second GO is ignored; a later GO computes 3! = 6.
REQ-040 Start N=10 and assert rst low after 4 BUSY cycles -> all outputs 0 immediately; a following N=4 GO yields RESULT=24.
